ch_tx: RTL

Channel transmitter feeding the two-phase (toggle) flit channel consumed by a router input port. It accepts flits from the local/switch side into a small FIFO, then drives them one at a time onto the channel. It uses a req/ack toggle handshake: a ch_req transition marks a new flit, and a ch_ack transition marks its consumption. It is the stage directly upstream of the router's receive logic and shares its clock and reset.

---
 rtl/ch_tx.sv | 103 ++++++++++
 1 files changed

// File: rtl/ch_tx.sv
// Channel transmitter: a small FIFO drained onto a two-phase req/ack toggle channel.
// Data is loaded one cycle before the request toggles and stays stable while a transfer is outstanding.
module ch_tx #(
  parameter int SIZE      = 8,
  parameter int BUFF_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [SIZE-1:0]      in_flit,
  output logic                 in_ready,
  output logic                 ch_req,
  output logic [SIZE-1:0]      ch_flit,
  input  logic                 ch_ack,
  output logic [BUFF_BITS:0]   count,
  output logic                 busy
);

  localparam int DEPTH = 1 << BUFF_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [SIZE-1:0]    mem [DEPTH];
  logic [BUFF_BITS:0] wr_ptr, rd_ptr;
  logic               ack_s1, ack_s2;
  logic               full, empty, wr_en;
  logic               fetch, req_toggle;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (BUFF_BITS+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign wr_en    = in_valid && in_ready;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt  = state;
    fetch      = 1'b0;
    req_toggle = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          fetch     = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        req_toggle = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        // Next fetch overlaps the acknowledge so queued flits skip ST_IDLE.
        if (ack_s2 == ch_req) begin
          if (!empty) begin
            fetch     = 1'b1;
            state_nxt = ST_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      ack_s1  <= 1'b0;
      ack_s2  <= 1'b0;
      ch_req  <= 1'b0;
      ch_flit <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state  <= state_nxt;
      ack_s1 <= ch_ack;
      ack_s2 <= ack_s1;
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (fetch) begin
        ch_flit <= mem[rd_ptr[BUFF_BITS-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (req_toggle)
        ch_req <= ~ch_req;
    end
  end

  // Storage needs no reset; a cleared pointer pair discards its contents.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[BUFF_BITS-1:0]] <= in_flit;
  end

endmodule
